// File: rtl/c_rr_lock_arbiter.sv
// c_rr_lock_arbiter: round-robin arbiter with packet lock.
//
// One output resource (switch output port or VC) is shared by num_ports
// requesters. Priority is a one-hot "last winner" pointer, turned into a
// thermometer mask that selects only requesters strictly after the last
// winner. When the lowest eligible request is a head flit of a multi-flit
// packet, the grant is locked to that owner until its tail flit is
// accepted. The pointer then moves to the owner.
//
// Parameters:
//   num_ports       number of requesters (>= 2)
//   watchdog_limit  silent locked cycles before a forced release
//                   (used only when C_RR_LOCK_WATCHDOG_EN is defined)
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   reset      synchronous, active-high reset
//   active     clock-gating qualifier; no state change while low
//   req        request vector, bit 0 = requester 0
//   tail       per-requester flag: current flit is a packet tail
//   gnt        zero or one-hot grant, combinational from req
//   gnt_valid  OR-reduction of gnt
//   locked     registered; high while a packet holds the lock
//   wd_error   registered one-cycle pulse on a watchdog release;
//              constant 0 without C_RR_LOCK_WATCHDOG_EN
//
// Optional feature macro: C_RR_LOCK_WATCHDOG_EN

// One-hot to thermometer conversion: therm[i] is set for every bit at or
// above the set bit of one_hot.
module c_one_hot_therm_conv #(
  parameter int width = 8
) (
  input  logic [width-1:0] one_hot,
  output logic [width-1:0] therm
);

  always_comb begin
    logic seen;
    seen  = 1'b0;
    therm = '0;
    for (int i = 0; i < width; i++) begin
      seen     = seen | one_hot[i];
      therm[i] = seen;
    end
  end

endmodule

module c_rr_lock_arbiter #(
  parameter int num_ports      = 8,
  parameter int watchdog_limit = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 active,
  input  logic [num_ports-1:0] req,
  input  logic [num_ports-1:0] tail,
  output logic [num_ports-1:0] gnt,
  output logic                 gnt_valid,
  output logic                 locked,
  output logic                 wd_error
);

  localparam logic [0:0] st_idle   = 1'b0;
  localparam logic [0:0] st_locked = 1'b1;

  logic [0:0]           st_q;
  logic [num_ports-1:0] prio_q;
  logic [num_ports-1:0] owner_q;

  logic [num_ports-1:0] prio_therm;
  logic [num_ports-1:0] mask;
  logic [num_ports-1:0] req_hi;
  logic [num_ports-1:0] pick;
  logic [num_ports-1:0] arb_gnt;
  logic                 gnt_tail;
  logic                 owner_req;
  logic                 owner_tail;
  logic                 wd_fire;
  logic                 release_lock;

  c_one_hot_therm_conv #(
    .width(num_ports)
  ) u_therm (
    .one_hot(prio_q),
    .therm  (prio_therm)
  );

  // The thermometer includes the last winner itself; clearing that bit
  // leaves only the requesters strictly after it.
  assign mask   = prio_therm & ~prio_q;
  assign req_hi = req & mask;

  // Lowest eligible requester above the pointer, otherwise wrap around to
  // the lowest requester overall.
  always_comb begin
    logic found;
    found   = 1'b0;
    arb_gnt = '0;
    pick    = (|req_hi) ? req_hi : req;
    for (int i = 0; i < num_ports; i++) begin
      if (pick[i] && !found) begin
        arb_gnt[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  // While locked only the owner can be granted, and only while it requests.
  always_comb begin
    gnt = arb_gnt;
    if (st_q == st_locked) begin
      gnt = owner_q & req;
    end
  end

  assign gnt_valid    = |gnt;
  assign gnt_tail     = |(gnt & tail);
  assign owner_req    = |(owner_q & req);
  assign owner_tail   = |(owner_q & req & tail);
  assign release_lock = owner_tail | wd_fire;
  assign locked       = (st_q == st_locked);

  // Arbitration state. A single-flit winner only moves the pointer; a head
  // flit takes the lock and the pointer waits until the packet ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= st_idle;
      prio_q  <= {1'b1, {(num_ports-1){1'b0}}};
      owner_q <= '0;
    end else if (active) begin
      if (st_q == st_idle) begin
        if (gnt_valid) begin
          if (gnt_tail) begin
            prio_q <= gnt;
          end else begin
            owner_q <= gnt;
            st_q    <= st_locked;
          end
        end
      end else if (release_lock) begin
        prio_q  <= owner_q;
        owner_q <= '0;
        st_q    <= st_idle;
      end
    end
  end

`ifdef C_RR_LOCK_WATCHDOG_EN
  localparam int wd_w = (watchdog_limit > 1) ? $clog2(watchdog_limit) : 1;
  localparam logic [wd_w-1:0] wd_last = wd_w'(watchdog_limit - 1);

  logic [wd_w-1:0] wd_cnt_q;
  logic            wd_error_q;

  assign wd_fire  = (st_q == st_locked) && !owner_req && (wd_cnt_q == wd_last);
  assign wd_error = wd_error_q;

  // Counts active locked cycles with a silent owner. Any owner request,
  // any idle cycle and the forced release itself restart the count. The
  // error flag is a single-cycle pulse, so it drops even on inactive cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_q   <= '0;
      wd_error_q <= 1'b0;
    end else begin
      wd_error_q <= 1'b0;
      if (active) begin
        if ((st_q != st_locked) || owner_req || wd_fire) begin
          wd_cnt_q <= '0;
        end else begin
          wd_cnt_q <= wd_cnt_q + 1'b1;
        end
        wd_error_q <= wd_fire;
      end
    end
  end
`else
  assign wd_fire = 1'b0;

  // Always 0; the comparison only keeps watchdog_limit referenced so both
  // builds share one parameter list.
  assign wd_error = (watchdog_limit < 0);
`endif

endmodule

// File: tb/tb_c_rr_lock_arbiter.sv
// tb_c_rr_lock_arbiter: self-checking bench for c_rr_lock_arbiter with
// num_ports = 4 and watchdog_limit = 4. A table of directed vectors with
// fixed expected outputs, a hand-written long-stall sequence and a random
// phase are all compared against a behavioural model that tracks the last
// winner and lock owner as plain indices.
module tb_c_rr_lock_arbiter;

  localparam int n        = 4;
  localparam int wd_limit = 4;

  logic         clk;
  logic         reset;
  logic         active;
  logic [n-1:0] req;
  logic [n-1:0] tail;
  logic [n-1:0] gnt;
  logic         gnt_valid;
  logic         locked;
  logic         wd_error;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  int m_last;
  bit m_lk;
  int m_owner;
  int m_silent;
  bit m_wd;

  typedef struct {
    logic         rst;
    logic         act;
    logic [n-1:0] rq;
    logic [n-1:0] tl;
    logic [n-1:0] exp_gnt;
    logic         exp_locked;
  } vec_t;

  vec_t vecs[$];

  c_rr_lock_arbiter #(
    .num_ports     (n),
    .watchdog_limit(wd_limit)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .active   (active),
    .req      (req),
    .tail     (tail),
    .gnt      (gnt),
    .gnt_valid(gnt_valid),
    .locked   (locked),
    .wd_error (wd_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addVec(input logic r, input logic a, input logic [n-1:0] rq,
                        input logic [n-1:0] tl, input logic [n-1:0] eg,
                        input logic el);
    vec_t v;
    v.rst        = r;
    v.act        = a;
    v.rq         = rq;
    v.tl         = tl;
    v.exp_gnt    = eg;
    v.exp_locked = el;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [n-1:0] actual,
                             input logic [n-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%b expected=%b time=%0t", name, actual, expected, $time);
    end
  endtask

  // Round-robin by circular scan starting just after the last winner.
  function automatic int modelWinner(input logic [n-1:0] rq);
    int idx;
    if (m_lk) return rq[m_owner] ? m_owner : -1;
    for (int k = 1; k <= n; k++) begin
      idx = (m_last + k) % n;
      if (rq[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [n-1:0] modelGnt(input logic [n-1:0] rq);
    logic [n-1:0] g;
    int w;
    g = '0;
    w = modelWinner(rq);
    if (w >= 0) g[w] = 1'b1;
    return g;
  endfunction

  task automatic modelReset();
    m_last   = n - 1;
    m_lk     = 1'b0;
    m_owner  = 0;
    m_silent = 0;
    m_wd     = 1'b0;
  endtask

  // Applies the inputs of the cycle that just ended at the clock edge.
  task automatic modelUpdate();
    int w;
    if (reset) begin
      modelReset();
    end else begin
      m_wd = 1'b0;
      if (active) begin
        if (!m_lk) begin
          w = modelWinner(req);
          if (w >= 0) begin
            if (tail[w]) begin
              m_last = w;
            end else begin
              m_lk     = 1'b1;
              m_owner  = w;
              m_silent = 0;
            end
          end
        end else if (req[m_owner] && tail[m_owner]) begin
          m_last   = m_owner;
          m_lk     = 1'b0;
          m_silent = 0;
        end else if (req[m_owner]) begin
          m_silent = 0;
        end
`ifdef C_RR_LOCK_WATCHDOG_EN
        else if (m_silent == wd_limit - 1) begin
          m_last   = m_owner;
          m_lk     = 1'b0;
          m_silent = 0;
          m_wd     = 1'b1;
        end else begin
          m_silent++;
        end
`endif
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic a,
                               input logic [n-1:0] rq, input logic [n-1:0] tl);
    reset  = r;
    active = a;
    req    = rq;
    tail   = tl;
    #1;
  endtask

  task automatic checkModel();
    logic [n-1:0] eg;
    eg = modelGnt(req);
    checkOutput("model_gnt", gnt, eg);
    checkOutput("model_gnt_valid", {3'b000, gnt_valid}, {3'b000, |eg});
    checkOutput("model_locked", {3'b000, locked}, {3'b000, m_lk});
    checkOutput("model_wd_error", {3'b000, wd_error}, {3'b000, m_wd});
  endtask

  task automatic advanceClock();
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    active = 1'b0;
    req    = '0;
    tail   = '0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();

    //      rst   act   req      tail     gnt      locked
    addVec(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    addVec(1'b0, 1'b1, 4'b1111, 4'b1111, 4'b0001, 1'b0);
    addVec(1'b0, 1'b1, 4'b1111, 4'b1111, 4'b0010, 1'b0);
    addVec(1'b0, 1'b1, 4'b1111, 4'b1111, 4'b0100, 1'b0);
    addVec(1'b0, 1'b1, 4'b1111, 4'b1111, 4'b1000, 1'b0);
    addVec(1'b0, 1'b1, 4'b1111, 4'b1111, 4'b0001, 1'b0);
    addVec(1'b0, 1'b1, 4'b0010, 4'b1111, 4'b0010, 1'b0);
    addVec(1'b0, 1'b1, 4'b0011, 4'b1111, 4'b0001, 1'b0);
    addVec(1'b0, 1'b1, 4'b0011, 4'b1111, 4'b0010, 1'b0);
    addVec(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    addVec(1'b0, 1'b1, 4'b0101, 4'b0000, 4'b0001, 1'b0);
    addVec(1'b0, 1'b1, 4'b0101, 4'b0000, 4'b0001, 1'b1);
    addVec(1'b0, 1'b1, 4'b0101, 4'b0000, 4'b0001, 1'b1);
    addVec(1'b0, 1'b1, 4'b0101, 4'b0000, 4'b0001, 1'b1);
    addVec(1'b0, 1'b1, 4'b0101, 4'b0001, 4'b0001, 1'b1);
    addVec(1'b0, 1'b1, 4'b0101, 4'b0000, 4'b0100, 1'b0);
    addVec(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    addVec(1'b0, 1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b1);
    addVec(1'b0, 1'b1, 4'b0100, 4'b0100, 4'b0100, 1'b1);
    addVec(1'b0, 1'b1, 4'b1111, 4'b1111, 4'b1000, 1'b0);
    addVec(1'b0, 1'b1, 4'b0010, 4'b0000, 4'b0010, 1'b0);
    addVec(1'b1, 1'b1, 4'b0010, 4'b0000, 4'b0010, 1'b1);
    addVec(1'b0, 1'b1, 4'b1111, 4'b1111, 4'b0001, 1'b0);
    addVec(1'b0, 1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b0);
    addVec(1'b0, 1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b0);
    addVec(1'b0, 1'b1, 4'b0100, 4'b0000, 4'b0100, 1'b0);
    addVec(1'b0, 1'b0, 4'b0100, 4'b0100, 4'b0100, 1'b1);
    addVec(1'b0, 1'b1, 4'b0100, 4'b0100, 4'b0100, 1'b1);
    addVec(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].act, vecs[i].rq, vecs[i].tl);
      checkOutput($sformatf("tbl%0d_gnt", i), gnt, vecs[i].exp_gnt);
      checkOutput($sformatf("tbl%0d_locked", i), {3'b000, locked},
                  {3'b000, vecs[i].exp_locked});
      checkModel();
      advanceClock();
    end

    // Long owner silence on port 3: the lock holds indefinitely, or the
    // watchdog forces a release when it is built in.
    applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0000);
    checkModel();
    advanceClock();
    applyStimulus(1'b0, 1'b1, 4'b1000, 4'b0000);
    checkModel();
    advanceClock();
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, 1'b1, 4'b0000, 4'b0000);
      checkModel();
      advanceClock();
    end
    applyStimulus(1'b0, 1'b1, 4'b1111, 4'b1111);
    checkModel();
    advanceClock();
    applyStimulus(1'b0, 1'b1, 4'b1000, 4'b1000);
    checkModel();
    advanceClock();

    // Random traffic; tail bits are sparse so packets span several flits.
    for (int k = 0; k < 500; k++) begin
      applyStimulus(($urandom_range(0, 63) == 0),
                    ($urandom_range(0, 7) != 0),
                    4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
      checkModel();
      advanceClock();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
